// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit queue: register addresses,
// drain FSM state encoding and the WAIT_BUSY timeout.
package uart_pkg;

    localparam logic [31:0] TXQ_DATA = 32'h4000_0024;
    localparam logic [31:0] TXQ_STAT = 32'h4000_0028;
    localparam logic [31:0] TXQ_CTRL = 32'h4000_002C;

    localparam int unsigned BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txq_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with synchronous flush; DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Memory-mapped byte queue that drains into the UART sender one frame at a time.
// Define UART_TXQ_IRQ_EN to build the low-water interrupt (irq_en, threshold).
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        tx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        irq
);

    txq_state_e       state;
    txq_state_e       state_nxt;
    logic [2:0]       busy_cnt;
    logic             wr_data;
    logic             wr_ctrl;
    logic             rd_stat;
    logic             flush;
    logic             pop;
    logic             overflow;
    logic             irq_en;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             unused_wdata;

    assign wr_data = wr && (addr == TXQ_DATA);
    assign wr_ctrl = wr && (addr == TXQ_CTRL);
    assign rd_stat = rd && (addr == TXQ_STAT);
    assign flush   = wr_ctrl && wdata[0];
    assign pop     = (state == IDLE) && !empty && tx_status;

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .flush   (flush),
        .push    (wr_data),
        .pop     (pop),
        .din     (wdata[7:0]),
        .dout    (fifo_dout),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // A dropped push outranks the read-clear so an overflow is never lost.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            overflow <= 1'b0;
        else if (flush)
            overflow <= 1'b0;
        else if (wr_data && full)
            overflow <= 1'b1;
        else if (rd_stat)
            overflow <= 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_status || busy_cnt == 3'(BUSY_TIMEOUT - 1))
                           state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_status) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // tx_en is registered off ISSUE, so it lands two edges after the push.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            busy_cnt <= '0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= (state == WAIT_BUSY) ? busy_cnt + 3'd1 : 3'd0;
            tx_en    <= (state == ISSUE);
            if (pop)
                tx_data <= fifo_dout;
        end
    end

`ifdef UART_TXQ_IRQ_EN
    logic [7:0] threshold;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_en    <= 1'b0;
            threshold <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en    <= wdata[1];
                threshold <= wdata[15:8];
            end
            irq <= irq_en && (32'(count) <= 32'(threshold)) && (state == IDLE);
        end
    end

    assign unused_wdata = ^wdata[31:16];
`else
    assign irq_en       = 1'b0;
    assign irq          = 1'b0;
    assign unused_wdata = ^wdata[31:8];
`endif

    always_comb begin
        rdata = '0;
        if (rd_stat) begin
            rdata[CNT_W+7:8] = count;
            rdata[3]         = irq_en;
            rdata[2]         = overflow;
            rdata[1]         = full;
            rdata[0]         = empty;
        end
    end

endmodule
